// File: rtl/arp_cache.sv
// arp_cache: IP-to-MAC cache with per-entry aging, free-slot-first / round-robin replacement
// and a same-IP back-to-back update bypass. Define ARP_CACHE_FLUSH_EN to add the i_flush port.
module arp_cache #(
  parameter int DEPTH     = 16,
  parameter int AGE_W     = 8,
  parameter int AGE_LIMIT = 200,
  parameter int TICK_DIV  = 156250
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_upd_valid,
  input  logic [31:0]              i_upd_ip,
  input  logic [47:0]              i_upd_mac,
  input  logic                     i_seek_valid,
  input  logic [31:0]              i_seek_ip,
`ifdef ARP_CACHE_FLUSH_EN
  input  logic                     i_flush,
`endif
  output logic                     o_seek_valid,
  output logic                     o_seek_hit,
  output logic [47:0]              o_seek_mac,
  output logic [$clog2(DEPTH):0]   o_count
);
  // Valid-only interfaces: a request is accepted on every cycle its valid is high; there is
  // no backpressure, and o_seek_valid is i_seek_valid delayed by exactly one cycle.
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TICK_DIV + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_LIMIT);

  logic flush;
`ifdef ARP_CACHE_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  logic [31:0]      tbl_ip  [DEPTH];
  logic [47:0]      tbl_mac [DEPTH];
  logic [AGE_W-1:0] tbl_age [DEPTH];
  logic [AGE_W-1:0] age_inc [DEPTH];
  logic [DEPTH-1:0] tbl_valid;

  logic             s1_valid, s1_hit;
  logic [IDX_W-1:0] s1_idx;
  logic [31:0]      s1_ip;
  logic [47:0]      s1_mac;

  logic             match_hit, free_found, wr_en, bypass, tick, seek_hit_c;
  logic [IDX_W-1:0] match_idx, free_idx, wr_idx, victim;
  logic [CNT_W-1:0] tick_cnt;
  logic [47:0]      seek_mac_c;
  logic [IDX_W:0]   cnt_c;

  // S1 compare: only valid entries can match, so IP 0 never hits a cleared slot.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl_valid[i] && tbl_ip[i] == i_upd_ip) begin
        match_hit = 1'b1;
        match_idx = IDX_W'(i);
      end
    end
  end

  // S2 target: hit index, else lowest free slot, else the round-robin victim.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!tbl_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    wr_en = s1_valid & ~flush;
    if (s1_hit)          wr_idx = s1_idx;
    else if (free_found) wr_idx = free_idx;
    else                 wr_idx = victim;
  end

  // A request following a write of the same IP reuses that write's slot.
  assign bypass = s1_valid && (s1_ip == i_upd_ip);
  assign tick   = (tick_cnt == CNT_W'(TICK_DIV - 1));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_inc[i] = (tbl_age[i] == AGE_MAX) ? AGE_MAX : tbl_age[i] + AGE_W'(1);
    end
  end

  always_comb begin
    seek_hit_c = 1'b0;
    seek_mac_c = '1;
    cnt_c      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl_valid[i] && tbl_ip[i] == i_seek_ip) begin
        seek_hit_c = 1'b1;
        seek_mac_c = tbl_mac[i];
      end
      cnt_c = cnt_c + (IDX_W + 1)'(tbl_valid[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_idx   <= '0;
      s1_ip    <= '0;
      s1_mac   <= '0;
    end else begin
      s1_valid <= i_upd_valid && (i_upd_ip != 32'd0) && !flush;
      s1_hit   <= bypass || match_hit;
      s1_idx   <= bypass ? wr_idx : match_idx;
      s1_ip    <= i_upd_ip;
      s1_mac   <= i_upd_mac;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      tbl_ip[wr_idx]  <= s1_ip;
      tbl_mac[wr_idx] <= s1_mac;
    end
  end

  // A write beats a same-cycle age tick on its entry; flush beats both.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tbl_valid <= '0;
      for (int i = 0; i < DEPTH; i++) tbl_age[i] <= '0;
    end else if (flush) begin
      tbl_valid <= '0;
      for (int i = 0; i < DEPTH; i++) tbl_age[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && wr_idx == IDX_W'(i)) begin
          tbl_valid[i] <= 1'b1;
          tbl_age[i]   <= '0;
        end else if (tick && tbl_valid[i]) begin
          tbl_age[i] <= age_inc[i];
          if (age_inc[i] >= AGE_LIM) tbl_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      victim       <= '0;
      tick_cnt     <= '0;
      o_seek_valid <= 1'b0;
      o_seek_hit   <= 1'b0;
      o_seek_mac   <= '1;
      o_count      <= '0;
    end else begin
      if (flush)
        victim <= '0;
      else if (wr_en && !s1_hit && !free_found)
        victim <= victim + IDX_W'(1);
      tick_cnt     <= tick ? '0 : tick_cnt + CNT_W'(1);
      o_seek_valid <= i_seek_valid;
      o_seek_hit   <= i_seek_valid && seek_hit_c;
      o_seek_mac   <= (i_seek_valid && seek_hit_c) ? seek_mac_c : '1;
      o_count      <= cnt_c;
    end
  end
endmodule

// File: tb/tb_arp_cache.sv
// Bench for arp_cache: directed scenarios plus randomized traffic against a table-level model.
// Define ARP_CACHE_FLUSH_EN for both files to exercise the flush port.
module tb_arp_cache;
  localparam int DEPTH     = 16;
  localparam int AGE_W     = 8;
  localparam int AGE_LIMIT = 20;
  localparam int TICK_DIV  = 4;
  localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_upd_valid = 1'b0;
  logic [31:0] i_upd_ip = '0;
  logic [47:0] i_upd_mac = '0;
  logic        i_seek_valid = 1'b0;
  logic [31:0] i_seek_ip = '0;
  logic        i_flush = 1'b0;
  logic        o_seek_valid, o_seek_hit;
  logic [47:0] o_seek_mac;
  logic [4:0]  o_count;

  int vec = 0;
  int fail = 0;

  arp_cache #(.DEPTH(DEPTH), .AGE_W(AGE_W), .AGE_LIMIT(AGE_LIMIT), .TICK_DIV(TICK_DIV)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_upd_valid(i_upd_valid), .i_upd_ip(i_upd_ip), .i_upd_mac(i_upd_mac),
    .i_seek_valid(i_seek_valid), .i_seek_ip(i_seek_ip),
`ifdef ARP_CACHE_FLUSH_EN
    .i_flush(i_flush),
`endif
    .o_seek_valid(o_seek_valid), .o_seek_hit(o_seek_hit), .o_seek_mac(o_seek_mac),
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  // Reference model: the table as plain arrays plus the one request waiting to be written.
  logic [31:0] m_ip  [DEPTH];
  logic [47:0] m_mac [DEPTH];
  bit          m_valid [DEPTH];
  int          m_age [DEPTH];
  int          m_victim, m_tick, m_count;
  bit          p_valid, p_hit;
  int          p_idx;
  logic [31:0] p_ip;
  logic [47:0] p_mac;
  logic [48:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0;
      m_age[i]   = 0;
    end
    m_victim = 0; m_tick = 0; m_count = 0;
    p_valid = 0; p_hit = 0; p_idx = 0;
  endtask

  task automatic model_edge();
    bit s_hit, n_valid, n_hit, tick;
    logic [47:0] s_mac;
    int widx, n_idx, cnt;
    s_hit = 0; s_mac = ONES; cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_seek_valid && m_valid[i] && m_ip[i] == i_seek_ip) begin
        s_hit = 1; s_mac = m_mac[i];
      end
      cnt += int'(m_valid[i]);
    end
    if (i_seek_valid) exp_q.push_back({s_hit, s_mac});
    widx = -1;
    if (p_valid && !i_flush) begin
      if (p_hit) widx = p_idx;
      else begin
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_valid[i]) widx = i;
        if (widx < 0) begin
          widx = m_victim;
          m_victim = (m_victim + 1) % DEPTH;
        end
      end
    end
    n_valid = i_upd_valid && i_upd_ip != 0 && !i_flush;
    n_hit = 0; n_idx = 0;
    if (widx >= 0 && p_ip == i_upd_ip) begin
      n_hit = 1; n_idx = widx;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (m_valid[i] && m_ip[i] == i_upd_ip) begin n_hit = 1; n_idx = i; end
    end
    tick = (m_tick == TICK_DIV - 1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i_flush) begin
        m_valid[i] = 0; m_age[i] = 0;
      end else if (i == widx) begin
        m_ip[i] = p_ip; m_mac[i] = p_mac; m_valid[i] = 1; m_age[i] = 0;
      end else if (tick && m_valid[i]) begin
        if (m_age[i] < 2**AGE_W - 1) m_age[i]++;
        if (m_age[i] >= AGE_LIMIT) m_valid[i] = 0;
      end
    end
    if (i_flush) m_victim = 0;
    m_tick  = tick ? 0 : m_tick + 1;
    m_count = cnt;
    p_valid = n_valid; p_hit = n_hit; p_idx = n_idx; p_ip = i_upd_ip; p_mac = i_upd_mac;
  endtask

  // Driver tasks: inputs change at negedge, the model advances at posedge.
  task automatic step();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic learn(input logic [31:0] ip, input logic [47:0] mac);
    i_upd_valid = 1'b1; i_upd_ip = ip; i_upd_mac = mac;
    step();
    i_upd_valid = 1'b0;
  endtask

  task automatic seek(input logic [31:0] ip);
    i_seek_valid = 1'b1; i_seek_ip = ip;
    step();
    i_seek_valid = 1'b0;
  endtask

  task automatic test_reset();
    vec++;
    if (o_seek_valid !== 1'b0 || o_seek_hit !== 1'b0 || o_seek_mac !== ONES || o_count !== 5'd0) begin
      fail++;
      $display("FAIL reset_outputs got v=%b h=%b mac=%h cnt=%0d exp v=0 h=0 mac=%h cnt=0",
               o_seek_valid, o_seek_hit, o_seek_mac, o_count, ONES);
    end
    seek(32'hC0A8_010A);
    vec++;
    if (o_seek_valid !== 1'b1 || o_seek_hit !== 1'b0 || o_seek_mac !== ONES || o_count !== 5'd0) begin
      fail++;
      $display("FAIL reset_seek got v=%b h=%b mac=%h cnt=%0d exp v=1 h=0 mac=%h cnt=0",
               o_seek_valid, o_seek_hit, o_seek_mac, o_count, ONES);
    end
  endtask

  task automatic test_learn();
    learn(32'hC0A8_010A, 48'h000A_3501_0203);
    wait_cycles(2);
    seek(32'hC0A8_010A);
    vec++;
    if (o_seek_hit !== 1'b1 || o_seek_mac !== 48'h000A_3501_0203 || o_count !== 5'd1) begin
      fail++;
      $display("FAIL learn_hit got h=%b mac=%h cnt=%0d exp h=1 mac=000a35010203 cnt=1",
               o_seek_hit, o_seek_mac, o_count);
    end
    seek(32'h0);
    vec++;
    if (o_seek_valid !== 1'b1 || o_seek_hit !== 1'b0 || o_seek_mac !== ONES) begin
      fail++;
      $display("FAIL learn_seek_zero got v=%b h=%b mac=%h exp v=1 h=0 mac=%h",
               o_seek_valid, o_seek_hit, o_seek_mac, ONES);
    end
  endtask

  task automatic test_back_to_back();
    i_upd_valid = 1'b1; i_upd_ip = 32'h0A00_0005; i_upd_mac = 48'hAAAA_AAAA_0001;
    step();
    i_upd_mac = 48'hBBBB_BBBB_0002;
    step();
    i_upd_valid = 1'b0;
    wait_cycles(2);
    seek(32'h0A00_0005);
    vec++;
    if (o_seek_hit !== 1'b1 || o_seek_mac !== 48'hBBBB_BBBB_0002 || o_count !== 5'd2) begin
      fail++;
      $display("FAIL b2b_update got h=%b mac=%h cnt=%0d exp h=1 mac=bbbbbbbb0002 cnt=2",
               o_seek_hit, o_seek_mac, o_count);
    end
  endtask

  task automatic test_aging();
    learn(32'hC0A8_0064, 48'h0011_2233_4455);
    wait_cycles(70);
    seek(32'hC0A8_0064);
    vec++;
    if (o_seek_hit !== 1'b1 || o_seek_mac !== 48'h0011_2233_4455) begin
      fail++;
      $display("FAIL aging_alive got h=%b mac=%h exp h=1 mac=001122334455", o_seek_hit, o_seek_mac);
    end
    wait_cycles(20);
    seek(32'hC0A8_0064);
    vec++;
    if (o_seek_hit !== 1'b0 || o_seek_mac !== ONES || o_count !== 5'd0) begin
      fail++;
      $display("FAIL aging_expired got h=%b mac=%h cnt=%0d exp h=0 mac=%h cnt=0",
               o_seek_hit, o_seek_mac, o_count, ONES);
    end
  endtask

  task automatic test_replace();
    for (int k = 1; k <= 16; k++) learn(32'hAC10_0000 + 32'(k), 48'h0200_0000_0000 + 48'(k));
    wait_cycles(2);
    vec++;
    if (o_count !== 5'd16) begin
      fail++;
      $display("FAIL replace_full_count got %0d exp 16", o_count);
    end
    learn(32'hAC10_0011, 48'h0200_0000_0011);
    wait_cycles(2);
    seek(32'hAC10_0001);
    vec++;
    if (o_seek_hit !== 1'b0) begin
      fail++;
      $display("FAIL replace_evict0 got h=%b exp h=0", o_seek_hit);
    end
    seek(32'hAC10_0011);
    vec++;
    if (o_seek_hit !== 1'b1 || o_seek_mac !== 48'h0200_0000_0011 || o_count !== 5'd16) begin
      fail++;
      $display("FAIL replace_new17 got h=%b mac=%h cnt=%0d exp h=1 mac=020000000011 cnt=16",
               o_seek_hit, o_seek_mac, o_count);
    end
    learn(32'hAC10_0012, 48'h0200_0000_0012);
    wait_cycles(2);
    seek(32'hAC10_0002);
    vec++;
    if (o_seek_hit !== 1'b0) begin
      fail++;
      $display("FAIL replace_evict1 got h=%b exp h=0", o_seek_hit);
    end
    seek(32'hAC10_0012);
    vec++;
    if (o_seek_hit !== 1'b1 || o_seek_mac !== 48'h0200_0000_0012) begin
      fail++;
      $display("FAIL replace_new18 got h=%b mac=%h exp h=1 mac=020000000012", o_seek_hit, o_seek_mac);
    end
    seek(32'hAC10_0003);
    vec++;
    if (o_seek_hit !== 1'b1 || o_seek_mac !== 48'h0200_0000_0003) begin
      fail++;
      $display("FAIL replace_keep2 got h=%b mac=%h exp h=1 mac=020000000003", o_seek_hit, o_seek_mac);
    end
  endtask

  task automatic test_refresh();
    learn(32'hC0A8_00C8, 48'h00DE_AD00_BEEF);
    wait_cycles(60);
    learn(32'hC0A8_00C8, 48'h00DE_AD00_BEEF);
    wait_cycles(50);
    seek(32'hC0A8_00C8);
    vec++;
    if (o_seek_hit !== 1'b1 || o_seek_mac !== 48'h00DE_AD00_BEEF) begin
      fail++;
      $display("FAIL refresh_survives got h=%b mac=%h exp h=1 mac=00dead00beef", o_seek_hit, o_seek_mac);
    end
    wait_cycles(40);
    seek(32'hC0A8_00C8);
    vec++;
    if (o_seek_hit !== 1'b0) begin
      fail++;
      $display("FAIL refresh_expires got h=%b exp h=0", o_seek_hit);
    end
  endtask

  function automatic logic [31:0] rand_ip();
    if ($urandom_range(0, 15) == 0) return 32'h0;
    return 32'h0A00_0000 + 32'($urandom_range(1, 24));
  endfunction

  task automatic test_random();
    logic [48:0] exp;
    exp_q.delete();
    for (int k = 0; k < 600; k++) begin
      i_upd_valid  = 1'($urandom_range(0, 1));
      i_upd_ip     = rand_ip();
      i_upd_mac    = {16'($urandom), $urandom};
      i_seek_valid = 1'($urandom_range(0, 1));
      i_seek_ip    = rand_ip();
      step();
      vec++;
      if (o_count !== 5'(m_count)) begin
        fail++;
        $display("FAIL rand_count cycle %0d got %0d exp %0d", k, o_count, m_count);
      end
      vec++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        if (o_seek_valid !== 1'b1 || o_seek_hit !== exp[48] || o_seek_mac !== exp[47:0]) begin
          fail++;
          $display("FAIL rand_seek cycle %0d got v=%b h=%b mac=%h exp v=1 h=%b mac=%h",
                   k, o_seek_valid, o_seek_hit, o_seek_mac, exp[48], exp[47:0]);
        end
      end else if (o_seek_valid !== 1'b0 || o_seek_mac !== ONES) begin
        fail++;
        $display("FAIL rand_idle cycle %0d got v=%b mac=%h exp v=0 mac=%h", k, o_seek_valid, o_seek_mac, ONES);
      end
    end
    i_upd_valid = 1'b0; i_seek_valid = 1'b0;
  endtask

`ifdef ARP_CACHE_FLUSH_EN
  task automatic test_flush();
    for (int k = 1; k <= 5; k++) learn(32'hC0A8_0200 + 32'(k), 48'h0300_0000_0000 + 48'(k));
    wait_cycles(2);
    i_flush = 1'b1;
    i_upd_valid = 1'b1; i_upd_ip = 32'hC0A8_02FF; i_upd_mac = 48'h0300_0000_00FF;
    i_seek_valid = 1'b1; i_seek_ip = 32'hC0A8_0201;
    step();
    i_flush = 1'b0; i_upd_valid = 1'b0; i_seek_valid = 1'b0;
    vec++;
    if (o_seek_hit !== 1'b1 || o_seek_mac !== 48'h0300_0000_0001) begin
      fail++;
      $display("FAIL flush_preflush_seek got h=%b mac=%h exp h=1 mac=030000000001", o_seek_hit, o_seek_mac);
    end
    step();
    vec++;
    if (o_count !== 5'd0) begin
      fail++;
      $display("FAIL flush_count got %0d exp 0", o_count);
    end
    for (int k = 1; k <= 6; k++) begin
      seek((k == 6) ? 32'hC0A8_02FF : 32'hC0A8_0200 + 32'(k));
      vec++;
      if (o_seek_hit !== 1'b0 || o_seek_mac !== ONES) begin
        fail++;
        $display("FAIL flush_seek_%0d got h=%b mac=%h exp h=0 mac=%h", k, o_seek_hit, o_seek_mac, ONES);
      end
    end
  endtask
`endif

  task automatic test_reset_abort();
    learn(32'hC0A8_0A0A, 48'h0400_0000_0001);
    i_rst = 1'b1;
    #1;
    vec++;
    if (o_count !== 5'd0 || o_seek_valid !== 1'b0 || o_seek_mac !== ONES) begin
      fail++;
      $display("FAIL reset_async got cnt=%0d v=%b mac=%h exp cnt=0 v=0 mac=%h", o_count, o_seek_valid, o_seek_mac, ONES);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
    wait_cycles(2);
    seek(32'hC0A8_0A0A);
    vec++;
    if (o_seek_hit !== 1'b0 || o_count !== 5'd0) begin
      fail++;
      $display("FAIL reset_abort got h=%b cnt=%0d exp h=0 cnt=0", o_seek_hit, o_count);
    end
  endtask

  initial begin
    model_reset();
    i_rst = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    test_reset();
    test_learn();
    test_back_to_back();
    test_aging();
    test_replace();
    test_refresh();
    test_random();
`ifdef ARP_CACHE_FLUSH_EN
    test_flush();
`endif
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end
endmodule
